// File: rtl/edge_stream_src_pkg.sv
// Shared types for edge_stream_src: the {tag,value} word layout and the
// generator FSM state encoding.
package edge_stream_src_pkg;

    localparam int unsigned DATA_SIZE = 8;

    typedef struct packed {
        logic [DATA_SIZE-1:0] tag;
        logic [DATA_SIZE-1:0] value;
    } word_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGen  = 2'd1,
        StDone = 2'd2
    } gen_state_e;

endpackage

// File: rtl/src_fifo.sv
// Holding FIFO for edge_stream_src. Push/pop are qualified internally against
// full/empty; DEPTH must be a power of two (minimum 2) so the pointers wrap naturally.
module src_fifo
    import edge_stream_src_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [2*DATA_SIZE-1:0] wr_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [2*DATA_SIZE-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [2*DATA_SIZE-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   w_push_ok;
    logic                   w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: stale entries are never presented while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/edge_stream_src.sv
// Producer end of the PE ready/read handshake: host FIFO plus an optional
// incrementing-word generator enabled by the SRC_GEN_EN macro.
module edge_stream_src
    import edge_stream_src_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*DATA_SIZE-1:0] hostWrData,
    input  logic                   hostWrEn,
    output logic                   hostFull,
    output logic [2*DATA_SIZE-1:0] outData,
    output logic                   outDataReady,
    input  logic                   readOutData,
`ifdef SRC_GEN_EN
    input  logic                   genStart,
    input  logic [DATA_SIZE-1:0]   genTag,
    input  logic [DATA_SIZE-1:0]   genBase,
    input  logic [DATA_SIZE-1:0]   genCount,
    output logic                   genBusy,
    output logic                   genDone,
`endif
    output logic                   protoErr
);

    logic                   w_fifo_empty;
    logic                   w_fifo_pop;
    logic [2*DATA_SIZE-1:0] w_fifo_head;
    logic                   w_valid;
    word_t                  w_word;
    logic                   r_proto_err;

    src_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (hostWrEn),
        .wr_data (hostWrData),
        .pop     (w_fifo_pop),
        .full    (hostFull),
        .empty   (w_fifo_empty),
        .head    (w_fifo_head)
    );

`ifdef SRC_GEN_EN
    gen_state_e           r_state;
    gen_state_e           w_state_nxt;
    logic [DATA_SIZE-1:0] r_tag;
    logic [DATA_SIZE-1:0] r_cur;
    logic [DATA_SIZE-1:0] r_rem;
    logic [DATA_SIZE-1:0] w_tag_nxt;
    logic [DATA_SIZE-1:0] w_cur_nxt;
    logic [DATA_SIZE-1:0] w_rem_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = r_tag;
        w_cur_nxt   = r_cur;
        w_rem_nxt   = r_rem;
        w_valid     = ~w_fifo_empty;
        w_word      = w_fifo_head;
        w_fifo_pop  = readOutData & ~w_fifo_empty;
        genBusy     = 1'b0;
        genDone     = 1'b0;
        case (r_state)
            StIdle: begin
                if (genStart) begin
                    if (genCount != '0) begin
                        w_state_nxt = StGen;
                        w_tag_nxt   = genTag;
                        w_cur_nxt   = genBase;
                        w_rem_nxt   = genCount;
                    end else begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StGen: begin
                // Generator owns the port; the FIFO keeps filling but is not drained.
                genBusy    = 1'b1;
                w_valid    = 1'b1;
                w_word     = '{tag: r_tag, value: r_cur};
                w_fifo_pop = 1'b0;
                if (readOutData) begin
                    w_cur_nxt = r_cur + DATA_SIZE'(1);
                    w_rem_nxt = r_rem - DATA_SIZE'(1);
                    if (r_rem == DATA_SIZE'(1)) w_state_nxt = StDone;
                end
            end
            StDone: begin
                genBusy     = 1'b1;
                genDone     = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_tag   <= '0;
            r_cur   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
            r_cur   <= w_cur_nxt;
            r_rem   <= w_rem_nxt;
        end
    end
`else
    assign w_valid    = ~w_fifo_empty;
    assign w_word     = w_fifo_head;
    assign w_fifo_pop = readOutData & ~w_fifo_empty;
`endif

    // Valid and word depend only on registered state, never on readOutData.
    assign outDataReady = w_valid;
    assign outData      = w_valid ? w_word : '0;
    assign protoErr     = r_proto_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if ((hostWrEn && hostFull) || (readOutData && !w_valid)) begin
            r_proto_err <= 1'b1;
        end
    end

endmodule
